// File: rtl/shared_unit_arbiter_if.sv
// shared_unit_arbiter_if: request/grant bundle between requesters and the shared-unit arbiter
interface shared_unit_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] lock;
  logic [NREQ-1:0] gnt;
  logic            gnt_valid;
  logic [IDW-1:0]  gnt_id;
  logic [IDW+3:0]  hold_cnt;
  logic [CNTW-1:0] grant_count;
  modport master (output req, lock, input gnt, gnt_valid, gnt_id, hold_cnt, grant_count);
  modport slave  (input req, lock, output gnt, gnt_valid, gnt_id, hold_cnt, grant_count);
endinterface

// File: rtl/shared_unit_arbiter.sv
// shared_unit_arbiter: round-robin owner selection for one shared unit with bounded hold, lock and a handover gap
module shared_unit_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8,
  parameter int CNTW     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  shared_unit_arbiter_if.slave bus
);
  localparam int HW = IDW + 4;
  localparam logic [1:0] IDLE = 2'd0, OWN = 2'd1, GAP = 2'd2;
  logic [1:0]     state;
  logic [1:0]     sync;
  logic [IDW-1:0] rr_ptr, sel, nxt_ptr;
  logic           found, rel;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= 2'b00;
    else sync <= {sync[0], 1'b1};
  // Searching downward lets the lowest offset from rr_ptr win the last assignment
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (bus.req[(int'(rr_ptr) + i) % NREQ]) begin
        sel   = IDW'((int'(rr_ptr) + i) % NREQ);
        found = 1'b1;
      end
  end
  assign nxt_ptr = (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;
  assign rel = !bus.req[bus.gnt_id] ||
               (bus.hold_cnt >= HW'(MAX_HOLD) && !bus.lock[bus.gnt_id] && |(bus.req & ~bus.gnt));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state           <= IDLE;
      bus.gnt         <= '0;
      bus.gnt_valid   <= 1'b0;
      bus.gnt_id      <= '0;
      bus.hold_cnt    <= '0;
      bus.grant_count <= '0;
      rr_ptr          <= '0;
    end else if (sync[1]) begin
      if (state == OWN) begin
        if (rel) begin
          state         <= GAP;
          bus.gnt       <= '0;
          bus.gnt_valid <= 1'b0;
          bus.hold_cnt  <= '0;
        end else bus.hold_cnt <= bus.hold_cnt + HW'(~&bus.hold_cnt);
      end else if (found) begin
        state           <= OWN;
        bus.gnt         <= NREQ'(1) << sel;
        bus.gnt_valid   <= 1'b1;
        bus.gnt_id      <= sel;
        bus.hold_cnt    <= HW'(1);
        bus.grant_count <= bus.grant_count + CNTW'(~&bus.grant_count);
        rr_ptr          <= nxt_ptr;
      end else state <= IDLE;
    end
endmodule

// File: tb/tb_shared_unit_arbiter.sv
// tb_shared_unit_arbiter: directed and random stimulus checked against a behavioural ownership model
module tb_shared_unit_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0, errors = 0;
  int own, hold, cnt, ptr, last_id, age;
  shared_unit_arbiter_if #(.NREQ(N), .IDW(2), .CNTW(16)) bus ();
  shared_unit_arbiter_if #(.NREQ(N), .IDW(2), .CNTW(4))  bus_s ();
  assign bus_s.req  = bus.req;
  assign bus_s.lock = bus.lock;
  shared_unit_arbiter #(.NREQ(N), .IDW(2), .MAX_HOLD(8), .CNTW(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  shared_unit_arbiter #(.NREQ(N), .IDW(2), .MAX_HOLD(8), .CNTW(4))  u_sat (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    own = -1; hold = 0; cnt = 0; ptr = 0; last_id = 0; age = 0;
  endtask
  task automatic m_step();
    logic [N-1:0] oth;
    if (!rst_n) return;
    if (age < 3) begin
      age++;
      if (age < 3) return;
    end
    if (own >= 0) begin
      oth = bus.req & ~(N'(1) << own);
      if (!bus.req[own] || (hold >= 8 && !bus.lock[own] && oth != 0)) begin
        own = -1;
        hold = 0;
      end else if (hold < 63) hold++;
    end else
      for (int k = 0; k < N; k++)
        if (bus.req[(ptr + k) % N]) begin
          own = (ptr + k) % N;
          hold = 1;
          cnt++;
          ptr = (own + 1) % N;
          last_id = own;
          break;
        end
  endtask
  task automatic check_all();
    chk("gnt", bus.gnt, own >= 0 ? (1 << own) : 0);
    chk("gnt_valid", bus.gnt_valid, own >= 0 ? 1 : 0);
    chk("gnt_id", bus.gnt_id, last_id);
    chk("hold_cnt", bus.hold_cnt, hold);
    chk("grant_count", bus.grant_count, cnt > 65535 ? 65535 : cnt);
    chk("grant_count_sat", bus_s.grant_count, cnt > 15 ? 15 : cnt);
    chk("onehot0", $onehot0(bus.gnt), 1);
  endtask
  task automatic cycle();
    @(posedge clk);
    m_step();
    #1;
    check_all();
  endtask
  initial begin
    rst_n = 1'b0;
    bus.req = '0;
    bus.lock = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    bus.req = 4'b1111;
    repeat (3) cycle();
    chk("first_grant", bus.gnt, 4'b0001);
    repeat (5) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("async_gnt", bus.gnt, 0);
    chk("async_valid", bus.gnt_valid, 0);
    chk("async_count", bus.grant_count, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    chk("post_reset_grant", bus.gnt, 4'b0001);
    repeat (36) cycle();
    chk("rr_fifth_owner", bus.gnt, 4'b0001);
    chk("rr_count5", bus.grant_count, 5);
    bus.req = '0;
    repeat (3) cycle();
    bus.req = 4'b0100;
    cycle();
    chk("single_grant", bus.gnt, 4'b0100);
    repeat (19) cycle();
    chk("single_hold20", bus.hold_cnt, 20);
    bus.req = '0;
    cycle();
    chk("single_drop", bus.gnt, 0);
    cycle();
    bus.req = 4'b0010;
    cycle();
    chk("lock_owner", bus.gnt, 4'b0010);
    bus.lock = 4'b0010;
    bus.req = 4'b1010;
    repeat (30) cycle();
    chk("lock_kept", bus.gnt, 4'b0010);
    bus.lock = '0;
    cycle();
    chk("lock_gap", bus.gnt, 0);
    cycle();
    chk("lock_next", bus.gnt, 4'b1000);
    bus.req = '0;
    repeat (3) cycle();
    bus.req = 4'b0100;
    cycle();
    chk("simul_owner", bus.gnt, 4'b0100);
    bus.req = 4'b0101;
    repeat (7) cycle();
    chk("simul_hold8", bus.hold_cnt, 8);
    bus.req = 4'b0001;
    cycle();
    chk("simul_gap", bus.gnt, 0);
    cycle();
    chk("simul_next", bus.gnt, 4'b0001);
    for (int i = 0; i < 2000 && (i < 300 || cnt < 20); i++) begin
      if ($urandom_range(0, 2) == 0) bus.req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) bus.lock = N'($urandom_range(0, 15));
      cycle();
    end
    if (cnt >= 15) chk("sat_stop", bus_s.grant_count, 15);
    else chk("sat_budget", cnt, 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shared_unit_arbiter.md
Name: shared_unit_arbiter

Overview:
- Round-robin arbiter that shares one parameterised processing unit between NREQ requesters.
- Sits between the requesters and the single shared unit instance. It also drives the unit's select mux via gnt_id.
- Each grant lasts a bounded number of cycles, with an optional lock to extend a burst.
- A mandatory one-cycle handover gap separates consecutive owners, so the unit's inputs never switch owner within a cycle.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, 2, width of gnt_id; must satisfy 2**IDW >= NREQ.
- MAX_HOLD, 8, cycles an unlocked owner may keep the grant while another requester is waiting (>=1).
- CNTW, 16, width of the grant statistics counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request level; held high while the requester wants the unit.
- lock  input  NREQ  per-requester lock; while the owner's bit is high it cannot be preempted.
- gnt  output  NREQ  one-hot grant, registered; all zeros when no owner.
- gnt_valid  output  1  OR of gnt, registered.
- gnt_id  output  IDW  binary index of the owner; holds its last value when gnt_valid=0.
- hold_cnt  output  IDW+4  cycles the current owner has held the grant, counting from 1.
- grant_count  output  CNTW  total grants issued; saturates at all-ones.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, grant_count=0, rr_ptr=0.
- Deassertion of rst_n is synchronised internally (2 flops). Arbitration starts on the 3rd rising edge after rst_n rises.
- rr_ptr is the index searched first. After each grant to index k, rr_ptr = (k+1) mod NREQ, wrapping from NREQ-1 to 0.
- FSM states: IDLE, OWN, GAP.
- IDLE:
  - If any req bit is high at edge t, select the first high bit searching from rr_ptr upward with wrap.
  - At edge t+1: gnt=onehot(sel), gnt_valid=1, gnt_id=sel, hold_cnt=1, grant_count+1. Go to OWN.
  - If no req is high, stay in IDLE.
- OWN (owner o):
  - hold_cnt increments every cycle and saturates at all-ones.
  - Release condition A: req[o]=0.
  - Release condition B: hold_cnt>=MAX_HOLD, lock[o]=0, and any other req bit is high.
  - On either condition at edge t: at t+1 gnt=0, gnt_valid=0, hold_cnt=0, go to GAP.
  - Otherwise stay in OWN.
  - Both conditions true in the same cycle: treat as a single release.
  - lock[o] high with no other requester pending: keep ownership indefinitely.
- GAP:
  - Exactly one cycle with gnt=0.
  - Arbitrate in this cycle using the same rule as IDLE, on the req values at the GAP edge.
  - If a winner exists, grant at the next edge and go to OWN; otherwise go to IDLE.
- Preempted requester: keeps its req high and re-enters arbitration. Under rr_ptr order it is served last.
- lock bits of non-owners are ignored.
- req of the owner dropping and re-rising in the GAP cycle: counts as a fresh request with no priority.
- Reset asserted mid-OWN: gnt drops immediately (asynchronously). No partial state is retained.
- Latency, request to grant in IDLE: 1 cycle.
- Latency, release to next owner's grant: 2 cycles (one gap cycle).
- Invariants: gnt is always zero or one-hot; gnt_id is consistent with gnt whenever gnt_valid=1.

Test Plan:
- Reset: drive rst_n=0 mid-grant with req=4'b1111 -> gnt=0, gnt_valid=0, grant_count=0 immediately. After release, first grant at the 3rd edge goes to index 0.
- Single requester: req=4'b0100 for 20 cycles, no lock -> gnt=4'b0100 one cycle after req. hold_cnt rises 1..20 with no preemption (no contender). Dropping req gives gnt=0 at the next edge.
- Round-robin fairness with MAX_HOLD=8: req=4'b1111 held -> owners 0,1,2,3,0 in sequence. Each owns 8 cycles, separated by 1-cycle gaps; grant_count=5 after the 5th grant.
- Lock: owner 1 with lock[1]=1 and req[3]=1 for 30 cycles -> owner 1 keeps gnt for all 30 cycles. lock[1]=0 at cycle 30 -> gnt=0 next cycle, then gnt=4'b1000 one cycle later.
- Simultaneous release: owner 2 drops req at the same cycle hold_cnt hits MAX_HOLD, with req[0]=1 -> exactly one GAP cycle, then gnt=4'b0001, grant_count incremented once.
- Saturation: CNTW=4 with 20 grants -> grant_count stops at 15 and does not wrap.
